// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit MIPS-style core: opcodes, default widths
// and the fetch-stage state encoding.
package mips8_pkg;

   localparam int PC_W_DEF = 8;

   localparam logic [2:0] OP_LI   = 3'b000;
   localparam logic [2:0] OP_LW   = 3'b001;
   localparam logic [2:0] OP_SW   = 3'b010;
   localparam logic [2:0] OP_ADDI = 3'b011;
   localparam logic [2:0] OP_BEQ  = 3'b100;
   localparam logic [2:0] OP_SLTI = 3'b101;
   localparam logic [2:0] OP_R    = 3'b110;
   localparam logic [2:0] OP_J    = 3'b111;

   typedef enum logic [1:0] {
      BUBBLE = 2'd0,
      RUN    = 2'd1,
      LI_LO  = 2'd2
   } fetch_state_e;

   function automatic logic [2:0] opcode_of(input logic [7:0] word);
      return word[7:5];
   endfunction

endpackage

// File: rtl/mips_next_pc.sv
// Next-address arithmetic for the fetch stage: sequential address, branch
// and jump targets, and the li detect used by the sequencer. Purely
// combinational; all arithmetic wraps modulo 2^PC_W.
module mips_next_pc
   import mips8_pkg::*;
#(
   parameter int PC_W     = PC_W_DEF,
   parameter int BR_IMM_W = 2
) (
   input  logic [PC_W-1:0] fetch_pc,
   input  logic [PC_W-1:0] pc,
   input  logic [7:0]      instr,
   input  logic            branch,
   input  logic            zero,
   input  logic            jump,
   output logic [PC_W-1:0] seq_pc,
   output logic [PC_W-1:0] redirect_pc,
   output logic            redirect,
   output logic            is_li
);

   logic [PC_W-1:0] br_off;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] j_target;

   // Target selection; jump outranks a taken branch.
   always_comb begin
      seq_pc      = fetch_pc + PC_W'(1);
      br_off      = {{(PC_W-BR_IMM_W){instr[BR_IMM_W-1]}}, instr[BR_IMM_W-1:0]};
      br_target   = pc + PC_W'(1) + br_off;
      j_target    = {pc[PC_W-1:5], instr[4:0]};
      redirect    = jump | (branch & zero);
      redirect_pc = jump ? j_target : br_target;
      is_li       = (opcode_of(instr) == OP_LI);
   end

endmodule

// File: rtl/mips_fetch.sv
// Instruction-fetch stage: drives a 1-cycle ROM, presents one registered
// instruction per cycle, sequences the two-phase li and redirects on taken
// beq / j. A stall freezes every register.
// Optional build macro MIPS_FETCH_HALT_DETECT_EN adds a 'halted' output that
// latches on a jump to its own pc and freezes the stage until reset.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   BUBBLE | ROM word in flight, nothing valid presented
//   RUN    | valid instr presented (li upper half when it is an li)
//   LI_LO  | same li presented again as its lower half (lireg=1)
module mips_fetch
   import mips8_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              BR_IMM_W = 2,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            branch,
   input  logic            zero,
   input  logic            jump,
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_rdata,
   output logic [7:0]      instr,
   output logic            instr_valid,
   output logic            lireg,
   output logic [PC_W-1:0] pc
`ifdef MIPS_FETCH_HALT_DETECT_EN
   ,
   output logic            halted
`endif
);

   logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      instr_q, instr_d;
   logic            instr_valid_q, instr_valid_d;
   logic            lireg_q, lireg_d;
   fetch_state_e    state_q, state_d;

   logic [PC_W-1:0] seq_pc;
   logic [PC_W-1:0] redirect_pc;
   logic            redirect;
   logic            is_li;
   logic            halt_hit;
   logic            frozen;
   logic            load_next;

   mips_next_pc #(
      .PC_W     (PC_W),
      .BR_IMM_W (BR_IMM_W)
   ) u_next_pc (
      .fetch_pc    (fetch_pc_q),
      .pc          (pc_q),
      .instr       (instr_q),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .seq_pc      (seq_pc),
      .redirect_pc (redirect_pc),
      .redirect    (redirect),
      .is_li       (is_li)
   );

`ifdef MIPS_FETCH_HALT_DETECT_EN
   logic halted_q, halted_d;

   assign halt_hit = jump && (redirect_pc == pc_q);
   assign frozen   = halted_q;
   assign halted   = halted_q;
`else
   assign halt_hit = 1'b0;
   assign frozen   = 1'b0;
`endif

   // Fetch sequencer: BUBBLE/RUN/LI_LO transitions and register updates.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      lireg_d       = lireg_q;
      state_d       = state_q;
      load_next     = 1'b0;
`ifdef MIPS_FETCH_HALT_DETECT_EN
      halted_d      = halted_q;
`endif
      if (!stall && !frozen) begin
         case (state_q)
            BUBBLE: load_next = 1'b1;
            RUN: begin
               if (redirect) begin
                  // The sequential word already in flight is dropped.
                  instr_valid_d = 1'b0;
                  if (halt_hit) begin
`ifdef MIPS_FETCH_HALT_DETECT_EN
                     halted_d = 1'b1;
`endif
                  end else begin
                     fetch_pc_d = redirect_pc;
                     state_d    = BUBBLE;
                  end
               end else if (is_li) begin
                  // Hold the ROM address so the next word is still on
                  // imem_rdata when the lower half retires.
                  lireg_d = 1'b1;
                  state_d = LI_LO;
               end else begin
                  load_next = 1'b1;
               end
            end
            LI_LO:   load_next = 1'b1;
            default: state_d   = BUBBLE;
         endcase
         if (load_next) begin
            instr_d       = imem_rdata;
            pc_d          = fetch_pc_q;
            instr_valid_d = 1'b1;
            fetch_pc_d    = seq_pc;
            lireg_d       = 1'b0;
            state_d       = RUN;
         end
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         lireg_q       <= 1'b0;
         state_q       <= BUBBLE;
`ifdef MIPS_FETCH_HALT_DETECT_EN
         halted_q      <= 1'b0;
`endif
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         lireg_q       <= lireg_d;
         state_q       <= state_d;
`ifdef MIPS_FETCH_HALT_DETECT_EN
         halted_q      <= halted_d;
`endif
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign lireg       = lireg_q;
   assign pc          = pc_q;

endmodule

// File: tb/tb_mips_fetch.sv
// Bench for mips_fetch. The reference walks the program at ISA level
// (pc -> word -> next pc) and emits the sequence of presentations the
// decoder should see, one per unstalled cycle; a monitor compares them.
module tb_mips_fetch;
   import mips8_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       stall = 1'b0;
   logic       branch, zero, jump;
   logic [7:0] imem_addr, imem_rdata, instr, pc;
   logic       instr_valid, lireg;
`ifdef MIPS_FETCH_HALT_DETECT_EN
   logic       halted;
`endif

   logic [7:0] rom [256];
   bit         zero_tab [256];

   // fetch_pc is the ROM address register; the word at that address is
   // what the fetch stage captures on the next edge.
   assign imem_rdata = rom[imem_addr];

   typedef struct {
      logic       valid;
      logic [7:0] instr;
      logic [7:0] pc;
      logic       lireg;
      logic [7:0] addr;
      logic       halted;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       cur;
   bit         have_cur = 0;
   bit         adv = 1;
   int         tests = 0;
   int         fails = 0;
   logic [2:0] junk = 3'b000;
   int         stall_pct = 0;
   int         li_stall_left = 0;
   bit         li_stall_armed = 0;
   string      tname = "reset";

   always #5 clk = ~clk;

   mips_fetch #(.PC_W(8), .BR_IMM_W(2), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .branch      (branch),
      .zero        (zero),
      .jump        (jump),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .lireg       (lireg),
      .pc          (pc)
`ifdef MIPS_FETCH_HALT_DETECT_EN
      ,
      .halted      (halted)
`endif
   );

   // Decoder stand-in; when nothing real is presented (bubble or li lower
   // half) the flags are garbage and must be ignored.
   always_comb begin
      branch = 1'b0;
      zero   = 1'b0;
      jump   = 1'b0;
      if (instr_valid && !lireg) begin
         jump   = (instr[7:5] == OP_J);
         branch = (instr[7:5] == OP_BEQ);
         zero   = zero_tab[pc];
      end else begin
         {branch, zero, jump} = junk;
      end
   end

   always @(posedge clk) adv <= !rst_n || !stall;

   // Stall and junk-flag driver.
   initial forever begin
      @(posedge clk);
      #1;
      junk = 3'($urandom);
      if (li_stall_armed && lireg) begin
         li_stall_left  = 3;
         li_stall_armed = 0;
      end
      if (!rst_n) stall = 1'b0;
      else if (li_stall_left > 0) begin
         stall = 1'b1;
         li_stall_left--;
      end else stall = ($urandom_range(99) < stall_pct);
   end

   task automatic check_cur();
      bit ok;
      ok = (instr_valid === cur.valid) && (imem_addr === cur.addr);
      if (cur.valid)
         ok = ok && (instr === cur.instr) && (pc === cur.pc) && (lireg === cur.lireg);
`ifdef MIPS_FETCH_HALT_DETECT_EN
      ok = ok && (halted === cur.halted);
`endif
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got v=%0b instr=%h pc=%h lireg=%0b addr=%h, want v=%0b instr=%h pc=%h lireg=%0b addr=%h halted=%0b",
                  tname, instr_valid, instr, pc, lireg, imem_addr,
                  cur.valid, cur.instr, cur.pc, cur.lireg, cur.addr, cur.halted);
      end
   endtask

   // Monitor: a new presentation appears after every unstalled edge.
   initial forever begin
      @(negedge clk);
      if (!rst_n) have_cur = 0;
      else begin
         if (adv) begin
            if (exp_q.size() > 0) begin
               cur      = exp_q.pop_front();
               have_cur = 1;
            end else have_cur = 0;
         end
         if (have_cur) check_cur();
      end
   end

   task automatic push(input logic v, input logic [7:0] w, input logic [7:0] p,
                       input logic l, input logic [7:0] a, input logic h);
      exp_t e;
      e.valid = v; e.instr = w; e.pc = p; e.lireg = l; e.addr = a; e.halted = h;
      exp_q.push_back(e);
   endtask

   // ISA-level walk of the program from the reset address.
   task automatic build_expect(input int n);
      logic [7:0] p, w, t;
      p = 8'h00;
      push(0, 8'h00, 8'h00, 0, p, 0);
      while (exp_q.size() < n) begin
         w = rom[p];
         push(1, w, p, 0, p + 8'd1, 0);
         if (w[7:5] == OP_J) begin
            t = {p[7:5], w[4:0]};
`ifdef MIPS_FETCH_HALT_DETECT_EN
            if (t == p) begin
               while (exp_q.size() < n) push(0, 8'h00, 8'h00, 0, p + 8'd1, 1);
               break;
            end
`endif
            push(0, 8'h00, 8'h00, 0, t, 0);
            p = t;
         end else if (w[7:5] == OP_BEQ && zero_tab[p]) begin
            t = p + 8'd1 + {{6{w[1]}}, w[1:0]};
            push(0, 8'h00, 8'h00, 0, t, 0);
            p = t;
         end else begin
            if (w[7:5] == OP_LI) push(1, w, p, 1, p + 8'd1, 0);
            p = p + 8'd1;
         end
      end
   endtask

   task automatic fill(input logic [7:0] w);
      for (int i = 0; i < 256; i++) begin
         rom[i]      = w;
         zero_tab[i] = 0;
      end
   endtask

   task automatic drain(input int limit);
      int c = 0;
      while (exp_q.size() > 0 && c < limit) begin
         @(posedge clk);
         c++;
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL %s timeout: got %0d items left, want 0", tname, exp_q.size());
      end
      @(negedge clk);
   endtask

   task automatic run_test(input string name, input int n, input int pct);
      tname     = name;
      stall_pct = pct;
      rst_n     = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      build_expect(n);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drain(n * 8 + 40);
      stall_pct      = 0;
      li_stall_armed = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fill(8'h61);
      rom[0] = 8'h61; rom[1] = 8'h62; rom[2] = 8'h63;
      run_test("addi_seq", 6, 0);

      fill(8'h61);
      rom[0] = 8'h05; rom[1] = 8'h61;
      li_stall_armed = 1;
      run_test("li_stall", 8, 0);

      fill(8'h61);
      rom[3] = 8'hE9; rom[4] = 8'h7F; rom[9] = 8'h6A;
      run_test("jump", 10, 0);

      fill(8'h61);
      rom[5] = 8'h83; zero_tab[5] = 1;
      run_test("beq_taken", 14, 0);

      fill(8'h61);
      rom[5] = 8'h83;
      run_test("beq_not_taken", 10, 0);

      fill(8'h61);
      rom[40] = 8'hE3;
      run_test("jump_high", 80, 20);

      fill(8'h61);
      rom[4] = 8'hE4;
      run_test("self_jump", 20, 20);

      fill(8'h61);
      run_test("wrap", 262, 0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 256; i++) begin
            rom[i]      = 8'($urandom);
            zero_tab[i] = 1'($urandom);
         end
         run_test($sformatf("random%0d", r), 120, 25);
      end

      // Reset dropped in the middle of an li.
      fill(8'h05);
      tname = "reset_mid_li";
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      build_expect(40);
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 20 && !lireg; c++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      tests++;
      if (instr !== 8'h00 || instr_valid !== 1'b0 || lireg !== 1'b0 ||
          pc !== 8'h00 || imem_addr !== 8'h00) begin
         fails++;
         $display("FAIL reset_values: got instr=%h v=%0b lireg=%0b pc=%h addr=%h, want all 0",
                  instr, instr_valid, lireg, pc, imem_addr);
      end
      fill(8'h61);
      rom[0] = 8'h05;
      @(posedge clk);
      build_expect(10);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drain(200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
